// File: rtl/arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

   // Read data returned on a watchdog abort; truncated to XLEN at the point of use.
   localparam logic [63:0] ERR_RDATA = 64'hDEAD_BEEF;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first valid requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
module rr_priority_pick #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
   output logic                       any_valid,
   output logic [$clog2(NUM_REQ)-1:0] winner_idx
);

   localparam int unsigned IDW = $clog2(NUM_REQ);

   // Scan offsets from farthest to nearest so the nearest valid index wins.
   always_comb begin
      int unsigned sum;
      logic [IDW-1:0] idx;
      any_valid  = |req_valid;
      winner_idx = '0;
      sum        = 0;
      idx        = '0;
      for (int unsigned off = NUM_REQ; off > 0; off--) begin
         sum = int'(rr_ptr) + off - 1;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = IDW'(sum);
         if (req_valid[idx]) winner_idx = idx;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ masters.
// Optional watchdog in BUSY enabled by defining ARB_TIMEOUT_EN.
module mem_req_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*XLEN-1:0]     req_addr,
   input  logic [NUM_REQ*XLEN-1:0]     req_wdata,
   input  logic [NUM_REQ*XLEN/8-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [XLEN-1:0]             req_rdata,
   output logic                        mem_valid,
   output logic [XLEN-1:0]             mem_addr,
   output logic [XLEN-1:0]             mem_wdata,
   output logic [XLEN/8-1:0]           mem_wstrb,
   input  logic                        mem_ready,
   input  logic [XLEN-1:0]             mem_rdata,
   output logic                        busy,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        bus_err
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned SW  = XLEN / 8;

   arb_state_t     state, state_next;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] winner_idx;
   logic           any_valid;
   logic           done;
   logic           err_hit;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid  (req_valid),
      .rr_ptr     (rr_ptr),
      .any_valid  (any_valid),
      .winner_idx (winner_idx)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [XLEN-1:0] ERR_WORD = XLEN'(ERR_RDATA);

   logic [CW-1:0] wd_cnt;

   assign err_hit = (state == ARB_BUSY) && !mem_ready && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Watchdog: held at zero in IDLE, counts stalled BUSY cycles.
   always_ff @(posedge clk) begin
      if (!reset || state == ARB_IDLE) wd_cnt <= '0;
      else if (!mem_ready)             wd_cnt <= wd_cnt + CW'(1);
   end

   assign req_rdata = err_hit ? ERR_WORD : mem_rdata;
`else
   assign err_hit   = 1'b0;
   assign req_rdata = mem_rdata;
`endif

   // Completion is suppressed in a reset cycle so an aborted transfer never pulses ready.
   assign req_ready = (done && reset) ? (NUM_REQ'(1) << grant_id) : '0;
   assign bus_err   = err_hit && reset;
   assign mem_valid = (state == ARB_BUSY);
   assign busy      = (state == ARB_BUSY);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ARB_IDLE;
      else        state <= state_next;
   end

   // Next-state and completion decode.
   always_comb begin
      state_next = state;
      done       = 1'b0;
      case (state)
         ARB_IDLE: if (any_valid) state_next = ARB_BUSY;
         ARB_BUSY: begin
            if (mem_ready || err_hit) begin
               done       = 1'b1;
               state_next = ARB_IDLE;
            end
         end
         default:  state_next = ARB_IDLE;
      endcase
   end

   // Grant latch, downstream request hold and rotation pointer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr    <= '0;
         grant_id  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (state == ARB_IDLE && any_valid) begin
         grant_id  <= winner_idx;
         mem_addr  <= req_addr[winner_idx*XLEN +: XLEN];
         mem_wdata <= req_wdata[winner_idx*XLEN +: XLEN];
         mem_wstrb <= req_wstrb[winner_idx*SW +: SW];
      end else if (done) begin
         rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
   end

endmodule
